error_metric_accum: RTL

ERROR_METRIC_ACCUM -- requirements
Module: error_metric_accum

---
 rtl/error_metric_accum_if.sv | 35 +++
 rtl/error_metric_accum.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/error_metric_accum_if.sv
// error_metric_accum_if
// Bundles the sample stream and result bus of the error-metric accumulator.
//   master : host side; drives start/valid/exact/approx/last and reads the results.
//   slave  : accumulator side; drives ready and the result outputs.
// Parameters must match those of the error_metric_accum instance attached to it.
interface error_metric_accum_if #(
  parameter int W     = 16,
  parameter int CNT_W = 17,
  parameter int SUM_W = W + 1 + CNT_W
);
  logic                i_start;
  logic                i_valid;
  logic                o_ready;
  logic signed [W-1:0] i_exact;
  logic signed [W-1:0] i_approx;
  logic                i_last;
  logic [SUM_W-1:0]    o_sum_abs_err;
  logic [W:0]          o_max_abs_err;
  logic [W:0]          o_max_abs_exact;
  logic [CNT_W-1:0]    o_count;
  logic                o_done;
  logic                o_ovf;

  modport master (
    output i_start, i_valid, i_exact, i_approx, i_last,
    input  o_ready, o_sum_abs_err, o_max_abs_err, o_max_abs_exact,
           o_count, o_done, o_ovf
  );

  modport slave (
    input  i_start, i_valid, i_exact, i_approx, i_last,
    output o_ready, o_sum_abs_err, o_max_abs_err, o_max_abs_exact,
           o_count, o_done, o_ovf
  );
endinterface

// File: rtl/error_metric_accum.sv
// error_metric_accum
// Measures the error of an approximate multiplier against exact products over a
// run of samples: sum and maximum of |approx - exact|, maximum |exact| (the NMED
// normaliser) and the sample count, with a sticky count-saturation flag.
// Ports:
//   i_clk  : clock, all state on the rising edge
//   i_rst  : synchronous active-high reset (priority over everything)
//   bus    : error_metric_accum_if slave modport (start/valid/ready/exact/
//            approx/last in, accumulated results, done and ovf out)
//
// state | meaning
// IDLE  | after reset, waiting for i_start
// RUN   | accepting samples until one carrying i_last drains the pipeline
// DONE  | results final and held until i_start or reset
module error_metric_accum #(
  parameter int W     = 16,
  parameter int CNT_W = 17,
  parameter int SUM_W = W + 1 + CNT_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  error_metric_accum_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [W:0]       ONE_W1  = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_last_seen;
  logic             w_ready;
  logic             w_accept;
  logic             w_enter_run;

  logic [W:0]       w_exact_ext;
  logic [W:0]       w_approx_ext;
  logic [W:0]       w_diff;
  logic [W:0]       w_abs_diff;
  logic [W:0]       w_abs_exact;

  logic             r_s1_vld;
  logic             r_s1_last;
  logic [W:0]       r_s1_abs_diff;
  logic [W:0]       r_s1_abs_exact;

  logic [SUM_W-1:0] r_sum;
  logic [W:0]       r_max_err;
  logic [W:0]       r_max_exact;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;

  // Ready comes only from registered state so it never loops back on i_valid;
  // r_last_seen closes the door the cycle after the final sample is taken.
  assign w_ready     = (r_state == S_RUN) && !r_last_seen;
  assign w_accept    = bus.i_valid && w_ready;
  assign w_enter_run = (r_state != S_RUN) && bus.i_start;

  // Sign-extend to W+1 bits so the difference and both magnitudes are exact,
  // including the -2^(W-1) corner.
  assign w_exact_ext  = {bus.i_exact[W-1], bus.i_exact};
  assign w_approx_ext = {bus.i_approx[W-1], bus.i_approx};
  assign w_diff       = w_approx_ext - w_exact_ext;
  assign w_abs_diff   = w_diff[W] ? (~w_diff + ONE_W1) : w_diff;
  assign w_abs_exact  = w_exact_ext[W] ? (~w_exact_ext + ONE_W1) : w_exact_ext;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.i_start) w_state_nxt = S_RUN;
      S_RUN:   if (r_s1_vld && r_s1_last) w_state_nxt = S_DONE;
      S_DONE:  if (bus.i_start) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_seen    <= 1'b0;
      r_s1_vld       <= 1'b0;
      r_s1_last      <= 1'b0;
      r_s1_abs_diff  <= '0;
      r_s1_abs_exact <= '0;
      r_sum          <= '0;
      r_max_err      <= '0;
      r_max_exact    <= '0;
      r_count        <= '0;
      r_ovf          <= 1'b0;
    end else if (w_enter_run) begin
      r_last_seen    <= 1'b0;
      r_s1_vld       <= 1'b0;
      r_s1_last      <= 1'b0;
      r_sum          <= '0;
      r_max_err      <= '0;
      r_max_exact    <= '0;
      r_count        <= '0;
      r_ovf          <= 1'b0;
    end else begin
      // Stage 1: register magnitudes of the accepted sample.
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_last      <= bus.i_last;
        r_s1_abs_diff  <= w_abs_diff;
        r_s1_abs_exact <= w_abs_exact;
        if (bus.i_last) r_last_seen <= 1'b1;
      end
      // Stage 2: accumulate. The sum wraps modulo 2^SUM_W; the count saturates.
      if (r_s1_vld) begin
        r_sum <= r_sum + SUM_W'(r_s1_abs_diff);
        if (r_s1_abs_diff > r_max_err)    r_max_err   <= r_s1_abs_diff;
        if (r_s1_abs_exact > r_max_exact) r_max_exact <= r_s1_abs_exact;
        if (&r_count) begin
          r_ovf <= 1'b1;
        end else begin
          r_count <= r_count + CNT_ONE;
        end
      end
    end
  end

  assign bus.o_ready         = w_ready;
  assign bus.o_sum_abs_err   = r_sum;
  assign bus.o_max_abs_err   = r_max_err;
  assign bus.o_max_abs_exact = r_max_exact;
  assign bus.o_count         = r_count;
  assign bus.o_done          = (r_state == S_DONE);
  assign bus.o_ovf           = r_ovf;

endmodule
